// File: rtl/bcd_pkg.sv
// Shared BCD constants, FSM state encoding and a packed-digit slice helper.
// Imported by the digit adder, the serial adder top and its interface.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_MAX     = 9;
    localparam int BCD_CORR    = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit i of a packed BCD word, digit 0 in bits [3:0].
    function automatic logic [BCD_DIGIT_W-1:0] bcd_digit(
        input logic [63:0] v,
        input int unsigned i
    );
        return v[i*BCD_DIGIT_W +: BCD_DIGIT_W];
    endfunction

endpackage

// File: rtl/bcd_serial_adder_if.sv
// Operand/result bundle of the digit-serial BCD adder.
// master: start, a, b, cin out; busy, done, sum, cout, err in. slave: reverse.
interface bcd_serial_adder_if #(
    parameter int N_DIGITS = 4
);
    import bcd_pkg::*;

    localparam int W = BCD_DIGIT_W * N_DIGITS;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, err
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, err
    );

endinterface

// File: rtl/bcd_digit_add.sv
// Combinational one-digit BCD adder with decimal carry.
// Ports: a, b digits, ci carry-in; s result digit, co decimal carry-out.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a,
    input  logic [BCD_DIGIT_W-1:0] b,
    input  logic                   ci,
    output logic [BCD_DIGIT_W-1:0] s,
    output logic                   co
);

    logic [BCD_DIGIT_W:0] t;

    // Out-of-range digits go through the same correction; no saturation.
    always_comb begin
        t  = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, ci};
        co = (t > (BCD_DIGIT_W+1)'(BCD_MAX));
        s  = co ? (t[BCD_DIGIT_W-1:0] + BCD_DIGIT_W'(BCD_CORR))
                : t[BCD_DIGIT_W-1:0];
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial N-digit BCD adder: one digit pair per clock, LSD first.
// Ports: clk, rst_n (async active-low), bus (slave: operands in, result out).
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int N_DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_serial_adder_if.slave   bus
);

    localparam int W  = BCD_DIGIT_W * N_DIGITS;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    state_t state, state_n;

    logic [W-1:0]  sh_a, sh_b, sh_s, sum_q;
    logic [IW-1:0] idx;
    logic          carry, err_acc;
    logic          busy_q, done_q, cout_q, err_q;

    logic [BCD_DIGIT_W-1:0] da, db, ds;
    logic                   dco, dig_err, last;
    logic [W+3:0]           s_cat;
    logic [W-1:0]           s_next;

    assign da      = bcd_digit(64'(sh_a), 0);
    assign db      = bcd_digit(64'(sh_b), 0);
    assign dig_err = (da > BCD_DIGIT_W'(BCD_MAX)) | (db > BCD_DIGIT_W'(BCD_MAX));
    assign last    = (idx == IW'(N_DIGITS - 1));

    bcd_digit_add u_add (
        .a  (da),
        .b  (db),
        .ci (carry),
        .s  (ds),
        .co (dco)
    );

    // New digit enters at the top; after N shifts digit 0 sits at [3:0].
    // The concatenation keeps this legal for a single-digit build.
    assign s_cat  = {ds, sh_s};
    assign s_next = s_cat[W+3:4];

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (bus.start) state_n = RUN;
            RUN:     if (last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sh_a    <= '0;
            sh_b    <= '0;
            sh_s    <= '0;
            idx     <= '0;
            carry   <= 1'b0;
            err_acc <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state  <= state_n;
            busy_q <= (state_n != IDLE);
            done_q <= (state_n == DONE);
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        sh_a    <= bus.a;
                        sh_b    <= bus.b;
                        sh_s    <= '0;
                        carry   <= bus.cin;
                        idx     <= '0;
                        err_acc <= 1'b0;
                    end
                end
                RUN: begin
                    sh_a    <= sh_a >> BCD_DIGIT_W;
                    sh_b    <= sh_b >> BCD_DIGIT_W;
                    sh_s    <= s_next;
                    carry   <= dco;
                    err_acc <= err_acc | dig_err;
                    idx     <= idx + 1'b1;
                    if (last) begin
                        sum_q  <= s_next;
                        cout_q <= dco;
                        err_q  <= err_acc | dig_err;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (N_DIGITS=4).
// Directed cases plus random operands against a digit-rule reference model.
module tb_bcd_serial_adder;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [15:0] prev_sum = '0;

    bcd_serial_adder_if #(.N_DIGITS(N)) bus ();

    bcd_serial_adder #(.N_DIGITS(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: decimal digit rule applied position by position.
    task automatic model(input logic [15:0] ma, input logic [15:0] mb,
                         input logic mc, output logic [15:0] ms,
                         output logic mco, output logic me);
        int c, t, ad, bd;
        c = int'(mc);
        ms = '0;
        me = 1'b0;
        for (int i = 0; i < N; i++) begin
            ad = int'((ma >> (4 * i)) & 16'hF);
            bd = int'((mb >> (4 * i)) & 16'hF);
            if (ad > 9 || bd > 9) me = 1'b1;
            t = ad + bd + c;
            if (t > 9) begin
                t = (t + 6) % 16;
                c = 1;
            end else begin
                c = 0;
            end
            ms = ms | (16'(t) << (4 * i));
        end
        mco = (c != 0);
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_,
                          input logic tc, input bit rp, input string tag);
        logic [15:0] es;
        logic        ec, ee;
        int          busy_cnt, done_cnt, done_at;
        logic [15:0] got_s;
        logic        got_c, got_e;
        model(ta, tb_, tc, es, ec, ee);
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        got_s    = '0;
        got_c    = 1'b0;
        got_e    = 1'b0;
        @(posedge clk);
        #1;
        bus.a     = ta;
        bus.b     = tb_;
        bus.cin   = tc;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) chk({tag, "_held"}, 64'(bus.sum), 64'(prev_sum));
            if (i == 1 && rp) begin
                bus.start = 1'b1;
                bus.a     = 16'h1111;
            end
            if (i == 2) begin
                bus.start = 1'b0;
                bus.a     = 16'($urandom);
                bus.b     = 16'($urandom);
                bus.cin   = 1'($urandom);
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_at = i;
                got_s   = bus.sum;
                got_c   = bus.cout;
                got_e   = bus.err;
            end
        end
        chk({tag, "_busy"}, 64'(busy_cnt), 64'(N + 1));
        chk({tag, "_ndone"}, 64'(done_cnt), 64'd1);
        chk({tag, "_lat"}, 64'(done_at), 64'(N));
        chk({tag, "_sum"}, 64'(got_s), 64'(es));
        chk({tag, "_cout"}, 64'(got_c), 64'(ec));
        chk({tag, "_err"}, 64'(got_e), 64'(ee));
        chk({tag, "_hold"}, 64'(bus.sum), 64'(es));
        prev_sum = es;
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 7) == 0)
                v = v | (16'($urandom_range(10, 15)) << (4 * i));
            else
                v = v | (16'($urandom_range(0, 9)) << (4 * i));
        end
        return v;
    endfunction

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_sum", 64'(bus.sum), 64'd0);
        chk("rst_cout", 64'(bus.cout), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_busy", 64'(bus.busy), 64'd0);

        run_op(16'h1234, 16'h5678, 1'b0, 1'b0, "d1234");
        run_op(16'h9999, 16'h0001, 1'b0, 1'b0, "ripple");
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0, "cin");
        run_op(16'h4999, 16'h5000, 1'b1, 1'b0, "cinrip");
        run_op(16'h00A0, 16'h0000, 1'b0, 1'b0, "inval");
        run_op(16'h1234, 16'h5678, 1'b0, 1'b0, "errclr");
        run_op(16'h1234, 16'h5678, 1'b0, 1'b1, "repulse");

        // Asynchronous reset during RUN cycle 2.
        @(posedge clk);
        #1;
        bus.a     = 16'h9999;
        bus.b     = 16'h0001;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 64'(bus.busy), 64'd0);
        chk("mrst_done", 64'(bus.done), 64'd0);
        chk("mrst_sum", 64'(bus.sum), 64'd0);
        chk("mrst_cout", 64'(bus.cout), 64'd0);
        chk("mrst_err", 64'(bus.err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_sum = '0;
        run_op(16'h0005, 16'h0005, 1'b0, 1'b0, "post");

        for (int k = 0; k < 40; k++) begin
            run_op(rand_bcd(), rand_bcd(), 1'($urandom), 1'b0,
                   $sformatf("rnd%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
